// File: rtl/coin_session_ctrl_if.sv
// Coin/start inputs, counter digit readback and session control outputs of coin_session_ctrl.
// The master modport drives the operator and counter side; the slave modport is the controller.
interface coin_session_ctrl_if;
    logic       i_coin;
    logic       i_start;
    logic [3:0] i_mode_sel;
    logic [3:0] i_sec_ones;
    logic [3:0] i_sec_tens;
    logic [3:0] i_min_ones;
    logic [3:0] o_counter_input;
    logic       o_counter_enable;
    logic       o_counter_clear;
    logic [3:0] o_credit;
    logic       o_busy;
    logic       o_done;
    logic       o_coin_reject;

    modport master (
        output i_coin, i_start, i_mode_sel, i_sec_ones, i_sec_tens, i_min_ones,
        input  o_counter_input, o_counter_enable, o_counter_clear,
        input  o_credit, o_busy, o_done, o_coin_reject
    );

    modport slave (
        input  i_coin, i_start, i_mode_sel, i_sec_ones, i_sec_tens, i_min_ones,
        output o_counter_input, o_counter_enable, o_counter_clear,
        output o_credit, o_busy, o_done, o_coin_reject
    );
endinterface

// File: rtl/coin_session_ctrl.sv
// Credit-based session controller for the coin timer: start edge -> Busy/enable next cycle,
// limit -> enable drops same cycle, Done next cycle. No backpressure; every edge is acted on at once.
module coin_session_ctrl #(
    parameter int PRICE_SHORT = 1,
    parameter int PRICE_LONG  = 3,
    parameter int MAX_CREDIT  = 15
) (
    input  logic                i_clk,
    input  logic                i_reset,
    coin_session_ctrl_if.slave  io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_coin_q;
    logic       r_start_q;
    logic [3:0] r_credit;
    logic [3:0] r_counter_input;
    logic       r_busy;
    logic       r_done;
    logic       r_clear;
    logic       r_coin_reject;

    logic       w_coin_edge;
    logic       w_start_edge;
    logic [3:0] w_price;
    logic       w_accept;
    logic       w_coin_add;
    logic       w_coin_reject;
    logic [3:0] w_charge;
    logic [3:0] w_credit_next;
    logic       w_limit_hit;

    assign w_coin_edge  = io_bus.i_coin & ~r_coin_q;
    assign w_start_edge = io_bus.i_start & ~r_start_q;
    assign w_price      = (io_bus.i_mode_sel == 4'd1) ? 4'(PRICE_SHORT) : 4'(PRICE_LONG);

    // Out-of-range BCD digits simply never compare equal, so the session keeps running.
    always_comb begin
        w_limit_hit = 1'b0;
        if (r_counter_input == 4'd1)
            w_limit_hit = ({io_bus.i_min_ones, io_bus.i_sec_tens, io_bus.i_sec_ones} == {4'd1, 4'd5, 4'd9});
        else
            w_limit_hit = ({io_bus.i_min_ones, io_bus.i_sec_tens, io_bus.i_sec_ones} == {4'd9, 4'd5, 4'd9});
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_edge && (r_credit >= w_price)) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_limit_hit)
                    w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Coin and charge fold into one update; a coin at saturation is refused even alongside a start.
    always_comb begin
        w_coin_add    = w_coin_edge && (r_credit < 4'(MAX_CREDIT));
        w_coin_reject = w_coin_edge && (r_credit >= 4'(MAX_CREDIT));
        w_charge      = w_accept ? w_price : 4'd0;
        w_credit_next = r_credit + {3'd0, w_coin_add} - w_charge;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_IDLE;
            r_coin_q        <= io_bus.i_coin;
            r_start_q       <= io_bus.i_start;
            r_credit        <= 4'd0;
            r_counter_input <= 4'd0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_clear         <= 1'b0;
            r_coin_reject   <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_coin_q        <= io_bus.i_coin;
            r_start_q       <= io_bus.i_start;
            r_credit        <= w_credit_next;
            if (w_accept)
                r_counter_input <= io_bus.i_mode_sel;
            r_busy          <= (w_state_next == ST_RUN);
            r_done          <= (w_state_next == ST_DONE);
            r_clear         <= (w_state_next == ST_DONE);
            r_coin_reject   <= w_coin_reject;
        end
    end

    assign io_bus.o_counter_input  = r_counter_input;
    assign io_bus.o_counter_enable = ~i_reset & (r_state == ST_RUN) & ~w_limit_hit;
    assign io_bus.o_counter_clear  = r_clear | i_reset;
    assign io_bus.o_credit         = r_credit;
    assign io_bus.o_busy           = r_busy;
    assign io_bus.o_done           = r_done;
    assign io_bus.o_coin_reject    = r_coin_reject;

endmodule

// File: tb/tb_coin_session_ctrl.sv
// Directed bench for coin_session_ctrl: drives inputs 2 ns after each rising edge and
// checks outputs against hand-computed values before the next edge.
module tb_coin_session_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    coin_session_ctrl_if bus ();

    coin_session_ctrl #(
        .PRICE_SHORT (1),
        .PRICE_LONG  (3),
        .MAX_CREDIT  (15)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_digits(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        bus.i_min_ones = m;
        bus.i_sec_tens = t;
        bus.i_sec_ones = o;
    endtask

    task automatic coin_pulse();
        bus.i_coin = 1'b1;
        step();
        bus.i_coin = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.i_coin = 1'b0;
        bus.i_start = 1'b0;
        bus.i_mode_sel = 4'd0;
        set_digits(4'd0, 4'd0, 4'd0);

        // Reset state
        step();
        check("rst_clear", bus.o_counter_clear, 1);
        check("rst_credit", bus.o_credit, 0);
        check("rst_busy", bus.o_busy, 0);
        check("rst_enable", bus.o_counter_enable, 0);
        check("rst_cinput", bus.o_counter_input, 0);
        reset = 1'b0;
        step();
        check("post_rst_clear", bus.o_counter_clear, 0);
        check("post_rst_done", bus.o_done, 0);

        // Two coins then a short session
        bus.i_coin = 1'b1;
        step();
        check("coin1_credit", bus.o_credit, 1);
        bus.i_coin = 1'b0;
        step();
        coin_pulse();
        check("coin2_credit", bus.o_credit, 2);
        bus.i_mode_sel = 4'd1;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("s1_credit", bus.o_credit, 1);
        check("s1_busy", bus.o_busy, 1);
        check("s1_cinput", bus.o_counter_input, 1);
        check("s1_enable", bus.o_counter_enable, 1);
        set_digits(4'd1, 4'd5, 4'd9);
        #1;
        check("s1_limit_enable", bus.o_counter_enable, 0);
        step();
        check("s1_done", bus.o_done, 1);
        check("s1_clear", bus.o_counter_clear, 1);
        check("s1_busy_off", bus.o_busy, 0);
        check("s1_done_cinput", bus.o_counter_input, 1);
        set_digits(4'd0, 4'd0, 4'd0);
        step();
        check("s1_done_end", bus.o_done, 0);
        check("s1_clear_end", bus.o_counter_clear, 0);
        check("s1_idle_credit", bus.o_credit, 1);
        check("s1_idle_enable", bus.o_counter_enable, 0);

        // Long session: refused at 2 credits, accepted at 3
        coin_pulse();
        check("c3_credit", bus.o_credit, 2);
        bus.i_mode_sel = 4'd4;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("poor_busy", bus.o_busy, 0);
        check("poor_credit", bus.o_credit, 2);
        check("poor_cinput", bus.o_counter_input, 1);
        step();
        coin_pulse();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("long_credit", bus.o_credit, 0);
        check("long_cinput", bus.o_counter_input, 4);
        check("long_busy", bus.o_busy, 1);
        set_digits(4'd1, 4'd5, 4'd9);
        #1;
        check("long_short_lim_en", bus.o_counter_enable, 1);
        step();
        check("long_no_done", bus.o_done, 0);
        check("long_still_busy", bus.o_busy, 1);
        set_digits(4'd9, 4'd5, 4'd9);
        #1;
        check("long_lim_enable", bus.o_counter_enable, 0);
        step();
        check("long_done", bus.o_done, 1);
        set_digits(4'd0, 4'd0, 4'd0);
        step();

        // Saturation
        for (int i = 0; i < 15; i++) coin_pulse();
        check("sat_credit", bus.o_credit, 15);
        check("sat_no_reject", bus.o_coin_reject, 0);
        bus.i_coin = 1'b1;
        step();
        check("sat_reject", bus.o_coin_reject, 1);
        check("sat_credit_hold", bus.o_credit, 15);
        bus.i_coin = 1'b0;
        step();
        check("sat_reject_once", bus.o_coin_reject, 0);
        bus.i_mode_sel = 4'd1;
        bus.i_coin = 1'b1;
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("sat_start_credit", bus.o_credit, 14);
        check("sat_start_reject", bus.o_coin_reject, 1);
        check("sat_start_busy", bus.o_busy, 1);

        // Reset mid-run with coin still held
        reset = 1'b1;
        step();
        check("mid_rst_clear", bus.o_counter_clear, 1);
        check("mid_rst_credit", bus.o_credit, 0);
        check("mid_rst_enable", bus.o_counter_enable, 0);
        check("mid_rst_busy", bus.o_busy, 0);
        reset = 1'b0;
        step();
        check("mid_post_enable", bus.o_counter_enable, 0);
        check("mid_post_clear", bus.o_counter_clear, 0);
        step();
        check("held_coin_credit", bus.o_credit, 0);
        bus.i_coin = 1'b0;
        step();
        coin_pulse();
        check("repress_credit", bus.o_credit, 1);
        coin_pulse();
        check("pre_hold_credit", bus.o_credit, 2);

        // Start held across a whole session
        bus.i_mode_sel = 4'd1;
        bus.i_start = 1'b1;
        step();
        check("hold_busy", bus.o_busy, 1);
        check("hold_credit", bus.o_credit, 1);
        set_digits(4'd1, 4'd5, 4'd9);
        step();
        check("hold_done", bus.o_done, 1);
        set_digits(4'd0, 4'd0, 4'd0);
        step();
        step();
        step();
        check("hold_no_restart", bus.o_busy, 0);
        check("hold_credit_kept", bus.o_credit, 1);
        bus.i_start = 1'b0;
        step();
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        check("fresh_busy", bus.o_busy, 1);
        check("fresh_credit", bus.o_credit, 0);
        set_digits(4'd1, 4'd5, 4'd9);
        step();
        check("fresh_done", bus.o_done, 1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
